fetch_ctrl: RTL and testbench

//  Drives the PC register's nextPc and stall inputs from the instruction-fetch side.
//  - Fetches the instruction at the current pc over a valid/ready instruction-memory request

---
 rtl/fetch_ctrl_if.sv | 13 +
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and memory.
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding imem request, holds the fetched word for IF/ID,
// and steers the PC register (advance on handoff, redirect on branch).
module fetch_ctrl #(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] nextPc,
  output logic            pc_stall,
  input  logic            id_shouldStall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  fetch_ctrl_if.master    imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t state, state_n;
  logic   drop, drop_n;
  logic   cap;
  logic   accept;

  assign accept         = (state == S_HOLD) && !id_shouldStall && !branch_taken;
  assign if_valid       = (state == S_HOLD);
  assign imem.req_valid = (state == S_REQ);
  assign imem.req_addr  = pc;

  // Redirect wins over handoff; otherwise the PC register holds.
  always_comb begin
    nextPc   = pc;
    pc_stall = 1'b1;
    if (branch_taken) begin
      nextPc   = branch_target;
      pc_stall = 1'b0;
    end else if (accept) begin
      nextPc   = pc + XLEN'(INST_BYTES);
      pc_stall = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    drop_n  = drop;
    cap     = 1'b0;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        // A request accepted alongside a redirect fetches the old pc; mark it stale.
        if (imem.req_ready) begin
          state_n = S_WAIT;
          drop_n  = branch_taken;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          if (imem.resp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem.resp_valid) begin
          if (drop) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            state_n = S_HOLD;
            cap     = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (branch_taken || !id_shouldStall) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      drop    <= 1'b0;
      if_pc   <= '0;
      if_inst <= '0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      // pc is frozen while a request is in flight, so it still names the fetched word.
      if (cap) begin
        if_pc   <= pc;
        if_inst <= imem.resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed per-cycle vector bench for fetch_ctrl with a hand-sequenced reset corner.
module tb_fetch_ctrl;
  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] nextPc;
  logic            pc_stall;
  logic            id_shouldStall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;

  fetch_ctrl_if #(.XLEN(XLEN)) imem ();

  fetch_ctrl #(.XLEN(XLEN), .INST_BYTES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .nextPc         (nextPc),
    .pc_stall       (pc_stall),
    .id_shouldStall (id_shouldStall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (imem.master),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        st, br;
    logic [31:0] tg;
    logic        rdy, rv;
    logic [31:0] rd;
    logic        e_rqv, e_ps;
    logic [31:0] e_np;
    logic        e_ifv;
    logic [31:0] e_ifpc, e_ifi;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [31:0] p, input logic st, br, input logic [31:0] tg,
                     input logic rdy, rv, input logic [31:0] rd,
                     input logic rqv, ps, input logic [31:0] np,
                     input logic ifv, input logic [31:0] ifpc, ifi);
    vec_t t;
    t.pc = p; t.st = st; t.br = br; t.tg = tg; t.rdy = rdy; t.rv = rv; t.rd = rd;
    t.e_rqv = rqv; t.e_ps = ps; t.e_np = np; t.e_ifv = ifv; t.e_ifpc = ifpc; t.e_ifi = ifi;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic st, br, input logic [31:0] tg,
                       input logic rdy, rv, input logic [31:0] rd);
    pc = p; id_shouldStall = st; branch_taken = br; branch_target = tg;
    imem.req_ready = rdy; imem.resp_valid = rv; imem.resp_data = rd;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //  pc          st br tg            rdy rv rd            rqv ps nextPc        ifv if_pc         if_inst
    // zero-wait memory, three sequential instructions
    add(32'h0,       0, 0, 32'h0,        1, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,        32'h0);        // IDLE
    add(32'h0,       0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,        32'h0);        // REQ
    add(32'h0,       0, 0, 32'h0,        1, 1, 32'hA000_0000, 0, 1, 32'h0,         0, 32'h0,        32'h0);        // WAIT resp
    add(32'h0,       0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h4,         1, 32'h0,        32'hA000_0000);// HOLD accept
    add(32'h4,       0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0,        32'hA000_0000);
    add(32'h4,       0, 0, 32'h0,        1, 1, 32'hA000_0004, 0, 1, 32'h4,         0, 32'h0,        32'hA000_0000);
    add(32'h4,       0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h8,         1, 32'h4,        32'hA000_0004);
    add(32'h8,       0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h8,         0, 32'h4,        32'hA000_0004);
    add(32'h8,       0, 0, 32'h0,        1, 1, 32'hA000_0008, 0, 1, 32'h8,         0, 32'h4,        32'hA000_0004);
    add(32'h8,       0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'hC,         1, 32'h8,        32'hA000_0008);
    // decode stall for 5 cycles while holding
    add(32'hC,       0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'hC,         0, 32'h8,        32'hA000_0008);
    add(32'hC,       0, 0, 32'h0,        1, 1, 32'hA000_000C, 0, 1, 32'hC,         0, 32'h8,        32'hA000_0008);
    for (int i = 0; i < 5; i++)
      add(32'hC,     1, 0, 32'h0,        1, 0, 32'h0,         0, 1, 32'hC,         1, 32'hC,        32'hA000_000C);
    add(32'hC,       0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h10,        1, 32'hC,        32'hA000_000C);
    // memory not ready for 4 cycles, then a one-cycle-late response
    for (int i = 0; i < 4; i++)
      add(32'h10,    0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h10,        0, 32'hC,        32'hA000_000C);
    add(32'h10,      0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h10,        0, 32'hC,        32'hA000_000C);
    add(32'h10,      0, 0, 32'h0,        0, 0, 32'h0,         0, 1, 32'h10,        0, 32'hC,        32'hA000_000C);
    add(32'h10,      0, 0, 32'h0,        0, 1, 32'hB000_0010, 0, 1, 32'h10,        0, 32'hC,        32'hA000_000C);
    add(32'h10,      0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h14,        1, 32'h10,       32'hB000_0010);
    // redirect while waiting; stale response two cycles later is dropped
    add(32'h14,      0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h14,        0, 32'h10,       32'hB000_0010);
    add(32'h14,      0, 1, 32'h100,      1, 0, 32'h0,         0, 0, 32'h100,       0, 32'h10,       32'hB000_0010);
    add(32'h100,     0, 0, 32'h0,        1, 0, 32'h0,         0, 1, 32'h100,       0, 32'h10,       32'hB000_0010);
    add(32'h100,     0, 0, 32'h0,        1, 1, 32'hDEAD_0014, 0, 1, 32'h100,       0, 32'h10,       32'hB000_0010);
    add(32'h100,     0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h100,       0, 32'h10,       32'hB000_0010);
    add(32'h100,     0, 0, 32'h0,        1, 1, 32'hC000_0100, 0, 1, 32'h100,       0, 32'h10,       32'hB000_0010);
    add(32'h100,     0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h104,       1, 32'h100,      32'hC000_0100);
    // redirect in the same cycle the request is accepted
    add(32'h104,     0, 1, 32'h200,      1, 0, 32'h0,         1, 0, 32'h200,       0, 32'h100,      32'hC000_0100);
    add(32'h200,     0, 0, 32'h0,        1, 1, 32'hBAD0_0104, 0, 1, 32'h200,       0, 32'h100,      32'hC000_0100);
    add(32'h200,     0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h200,       0, 32'h100,      32'hC000_0100);
    add(32'h200,     0, 0, 32'h0,        1, 1, 32'hC000_0200, 0, 1, 32'h200,       0, 32'h100,      32'hC000_0100);
    add(32'h200,     0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h204,       1, 32'h200,      32'hC000_0200);
    // redirect while holding (beats decode stall), while REQ not ready, with a response in WAIT
    add(32'h204,     0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h204,       0, 32'h200,      32'hC000_0200);
    add(32'h204,     0, 0, 32'h0,        1, 1, 32'hC000_0204, 0, 1, 32'h204,       0, 32'h200,      32'hC000_0200);
    add(32'h204,     1, 1, 32'h300,      1, 0, 32'h0,         0, 0, 32'h300,       1, 32'h204,      32'hC000_0204);
    add(32'h300,     0, 1, 32'h400,      0, 0, 32'h0,         1, 0, 32'h400,       0, 32'h204,      32'hC000_0204);
    add(32'h400,     0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h400,       0, 32'h204,      32'hC000_0204);
    add(32'h400,     0, 1, 32'h500,      1, 1, 32'hBAD0_0400, 0, 0, 32'h500,       0, 32'h204,      32'hC000_0204);
    add(32'h500,     0, 0, 32'h0,        0, 1, 32'hBAD0_0500, 1, 1, 32'h500,       0, 32'h204,      32'hC000_0204);
    // pc wrap at the top of the address space
    add(32'h500,     0, 1, 32'hFFFF_FFFC,0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 0, 32'h204,      32'hC000_0204);
    add(32'hFFFF_FFFC,0,0, 32'h0,        1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h204,      32'hC000_0204);
    add(32'hFFFF_FFFC,0,0, 32'h0,        1, 1, 32'hE000_0000, 0, 1, 32'hFFFF_FFFC, 0, 32'h204,      32'hC000_0204);
    add(32'hFFFF_FFFC,0,0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFC,32'hE000_0000);
    add(32'h0,       0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h0,         0, 32'hFFFF_FFFC,32'hE000_0000);

    // reset state, checked while reset is held
    #2;
    chk("rst_req_valid", -1, 32'(imem.req_valid), 32'h0);
    chk("rst_pc_stall",  -1, 32'(pc_stall),       32'h1);
    chk("rst_if_valid",  -1, 32'(if_valid),       32'h0);
    chk("rst_if_pc",     -1, if_pc,               32'h0);
    chk("rst_if_inst",   -1, if_inst,             32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].pc, vq[i].st, vq[i].br, vq[i].tg, vq[i].rdy, vq[i].rv, vq[i].rd);
      #4;
      chk("req_valid", i, 32'(imem.req_valid), 32'(vq[i].e_rqv));
      chk("req_addr",  i, imem.req_addr,       vq[i].pc);
      chk("pc_stall",  i, 32'(pc_stall),       32'(vq[i].e_ps));
      chk("nextPc",    i, nextPc,              vq[i].e_np);
      chk("if_valid",  i, 32'(if_valid),       32'(vq[i].e_ifv));
      chk("if_pc",     i, if_pc,               vq[i].e_ifpc);
      chk("if_inst",   i, if_inst,             vq[i].e_ifi);
      @(posedge clock); #1;
    end

    // async reset while a fetch is in flight (DUT is in WAIT here)
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_req_valid", 100, 32'(imem.req_valid), 32'h0);
    chk("arst_pc_stall",  100, 32'(pc_stall),       32'h1);
    chk("arst_if_valid",  100, 32'(if_valid),       32'h0);
    chk("arst_if_pc",     100, if_pc,               32'h0);
    chk("arst_if_inst",   100, if_inst,             32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    // late response lands in IDLE, then in REQ: both ignored
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #4;
    chk("late_idle_req_valid", 101, 32'(imem.req_valid), 32'h0);
    chk("late_idle_if_valid",  101, 32'(if_valid),       32'h0);
    @(posedge clock); #1;
    #4;
    chk("late_req_req_valid",  102, 32'(imem.req_valid), 32'h1);
    chk("late_req_if_inst",    102, if_inst,             32'h0);
    @(posedge clock); #1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #4;
    chk("late_still_req",      103, 32'(imem.req_valid), 32'h1);
    chk("late_if_valid",       103, 32'(if_valid),       32'h0);
    @(posedge clock); #1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7700_0000);
    @(posedge clock); #1;
    drive(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #4;
    chk("post_rst_if_valid",   104, 32'(if_valid),       32'h1);
    chk("post_rst_if_pc",      104, if_pc,               32'h0);
    chk("post_rst_if_inst",    104, if_inst,             32'h7700_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
